// File: rtl/detector_jogada_pkg.sv
// ============================================================
// detector_jogada_pkg -- game constants shared by detector and controller
// Rev 1.0 -- initial release
// ============================================================
`default_nettype none

package detector_jogada_pkg;

  localparam int DEBOUNCE_CICLOS_PADRAO = 50000;
  localparam int DB_LARGURA             = 4;

  typedef enum logic [3:0] {
    OCIOSO        = 4'd0,
    FILTRA        = 4'd1,
    PULSO         = 4'd2,
    ESPERA_SOLTAR = 4'd3
  } estado_t;

  function automatic int largura_contador(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/detector_jogada_if.sv
// ============================================================
// detector_jogada_if -- button/controller bus of the play detector
// Rev 1.0 -- initial release
// ============================================================
`default_nettype none

interface detector_jogada_if #(
  parameter int N_BOTOES = 4
);
  import detector_jogada_pkg::*;

  logic [N_BOTOES-1:0]   botoes;
  logic                  habilita;
  logic                  zera;
  logic                  fez_jogada;
  logic [N_BOTOES-1:0]   jogada;
  logic [DB_LARGURA-1:0] db_estado;

  modport master (
    output botoes, habilita, zera,
    input  fez_jogada, jogada, db_estado
  );

  modport slave (
    input  botoes, habilita, zera,
    output fez_jogada, jogada, db_estado
  );

endinterface

`default_nettype wire

// File: rtl/sincronizador_2ff.sv
// ============================================================
// sincronizador_2ff -- two-flop synchronizer, reset to zero
// Rev 1.0 -- initial release
// ============================================================
`default_nettype none

module sincronizador_2ff #(
  parameter int LARGURA = 1
) (
  input  wire logic               clock,
  input  wire logic               reset,
  input  wire logic [LARGURA-1:0] d,
  output logic      [LARGURA-1:0] q
);

  logic [LARGURA-1:0] r_meta;
  logic [LARGURA-1:0] r_sinc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_meta <= '0;
      r_sinc <= '0;
    end else begin
      r_meta <= d;
      r_sinc <= r_meta;
    end
  end

  assign q = r_sinc;

endmodule

`default_nettype wire

// File: rtl/detector_jogada.sv
// ============================================================
// detector_jogada -- debounced single-button press detector
// Rev 1.0 -- initial release
// ============================================================
`default_nettype none

module detector_jogada
  import detector_jogada_pkg::*;
#(
  parameter int N_BOTOES        = 4,
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
  input  wire logic          clock,
  input  wire logic          reset,
  detector_jogada_if.slave   bus
);

  localparam int c_cont_largura = largura_contador(DEBOUNCE_CICLOS);
  localparam logic [c_cont_largura-1:0] c_cont_max = c_cont_largura'(DEBOUNCE_CICLOS - 1);

  logic [N_BOTOES-1:0]       w_sb;
  estado_t                   r_estado;
  estado_t                   w_prox_estado;
  logic [c_cont_largura-1:0] r_contador;
  logic [c_cont_largura-1:0] w_prox_contador;
  logic [N_BOTOES-1:0]       r_captura;
  logic [N_BOTOES-1:0]       w_prox_captura;
  logic [N_BOTOES-1:0]       r_jogada;
  logic [N_BOTOES-1:0]       w_prox_jogada;
  logic                      r_fez_jogada;
  logic                      w_um_botao;
  logic                      w_varios;
  logic                      w_cont_fim;

  sincronizador_2ff #(
    .LARGURA (N_BOTOES)
  ) u_sinc (
    .clock (clock),
    .reset (reset),
    .d     (bus.botoes),
    .q     (w_sb)
  );

  assign w_um_botao = $onehot(w_sb);
  assign w_varios   = (w_sb != '0) && !w_um_botao;
  assign w_cont_fim = (r_contador == c_cont_max);

  // The counter only advances below its terminal value, so it can never wrap.
  always_comb begin
    w_prox_estado   = r_estado;
    w_prox_contador = r_contador;
    w_prox_captura  = r_captura;
    w_prox_jogada   = r_jogada;
    if (bus.zera) begin
      w_prox_estado   = ESPERA_SOLTAR;
      w_prox_contador = '0;
      w_prox_captura  = '0;
      w_prox_jogada   = '0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          w_prox_contador = '0;
          if (bus.habilita && w_um_botao) begin
            w_prox_estado  = FILTRA;
            w_prox_captura = w_sb;
          end else if (bus.habilita && w_varios) begin
            w_prox_estado = ESPERA_SOLTAR;
          end
        end
        FILTRA: begin
          if ((w_sb != r_captura) || !bus.habilita) begin
            w_prox_contador = '0;
            w_prox_estado   = (w_sb == '0) ? OCIOSO : ESPERA_SOLTAR;
          end else if (w_cont_fim) begin
            w_prox_estado = PULSO;
            w_prox_jogada = r_captura;
          end else begin
            w_prox_contador = r_contador + 1'b1;
          end
        end
        PULSO: begin
          w_prox_estado   = ESPERA_SOLTAR;
          w_prox_contador = '0;
        end
        ESPERA_SOLTAR: begin
          if (w_sb != '0) begin
            w_prox_contador = '0;
          end else if (w_cont_fim) begin
            w_prox_estado   = OCIOSO;
            w_prox_contador = '0;
          end else begin
            w_prox_contador = r_contador + 1'b1;
          end
        end
        default: begin
          w_prox_estado   = OCIOSO;
          w_prox_contador = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado     <= OCIOSO;
      r_contador   <= '0;
      r_captura    <= '0;
      r_jogada     <= '0;
      r_fez_jogada <= 1'b0;
    end else begin
      r_estado     <= w_prox_estado;
      r_contador   <= w_prox_contador;
      r_captura    <= w_prox_captura;
      r_jogada     <= w_prox_jogada;
      r_fez_jogada <= (w_prox_estado == PULSO);
    end
  end

  assign bus.fez_jogada = r_fez_jogada;
  assign bus.jogada     = r_jogada;
  assign bus.db_estado  = r_estado;

endmodule

`default_nettype wire

// File: tb/tb_detector_jogada.sv
// ============================================================
// tb_detector_jogada -- directed bench with pulse scoreboard
// Rev 1.0 -- initial release
// ============================================================
`default_nettype none

module tb_detector_jogada;
  import detector_jogada_pkg::*;

  localparam int N = 4;
  localparam int D = 4;

  typedef struct {
    logic [N-1:0] jogada;
    int           ciclo;
  } pulso_t;

  logic   clock = 1'b0;
  logic   reset = 1'b0;
  int     checks = 0;
  int     failures = 0;
  int     ciclo = 0;
  pulso_t fila[$];
  pulso_t e;

  detector_jogada_if #(.N_BOTOES(N)) bus ();

  detector_jogada #(
    .N_BOTOES        (N),
    .DEBOUNCE_CICLOS (D)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) ciclo <= ciclo + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ciclos(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Expect a pulse 'atraso' edges after the edge just passed.
  task automatic prever(input logic [N-1:0] v, input int atraso);
    pulso_t p;
    p.jogada = v;
    p.ciclo  = ciclo + atraso;
    fila.push_back(p);
  endtask

  task automatic espera_estado(input string tag, input estado_t alvo, input int limite);
    int n = 0;
    while (bus.db_estado !== alvo && n < limite) begin
      @(negedge clock);
      n++;
    end
    chk(tag, 32'(bus.db_estado), 32'(alvo));
  endtask

  // Every observed pulse must match the oldest predicted one.
  always @(negedge clock) begin
    if (reset === 1'b1 && bus.fez_jogada === 1'b1) begin
      chk("pulso_previsto", {31'b0, fila.size() != 0}, 32'd1);
      if (fila.size() != 0) begin
        e = fila.pop_front();
        chk("pulso_ciclo", ciclo, e.ciclo);
        chk("pulso_jogada", 32'(bus.jogada), 32'(e.jogada));
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bus.botoes   = '0;
    bus.habilita = 1'b0;
    bus.zera     = 1'b0;
    ciclos(3);
    chk("reset_fez", 32'(bus.fez_jogada), 32'd0);
    chk("reset_jogada", 32'(bus.jogada), 32'd0);
    chk("reset_estado", 32'(bus.db_estado), 32'(OCIOSO));
    reset = 1'b1;
    ciclos(3);

    // Held press: one pulse D+3 edges after the drive point.
    bus.habilita = 1'b1;
    bus.botoes   = 4'b0010;
    prever(4'b0010, D + 3);
    ciclos(20);
    chk("held_jogada", 32'(bus.jogada), 32'h2);
    chk("held_estado", 32'(bus.db_estado), 32'(ESPERA_SOLTAR));
    bus.botoes = '0;
    espera_estado("held_solta", OCIOSO, 20);
    chk("held_jogada_mantida", 32'(bus.jogada), 32'h2);

    // Bounces shorter than the debounce window.
    bus.botoes = 4'b0100;
    ciclos(3);
    bus.botoes = '0;
    ciclos(3);
    bus.botoes = 4'b0100;
    ciclos(3);
    bus.botoes = '0;
    espera_estado("curto_ocioso", OCIOSO, 20);
    chk("curto_jogada", 32'(bus.jogada), 32'h2);

    // Two buttons together.
    bus.botoes = 4'b0011;
    ciclos(4);
    chk("multi_estado", 32'(bus.db_estado), 32'(ESPERA_SOLTAR));
    bus.botoes = '0;
    ciclos(5);
    chk("multi_ainda_espera", 32'(bus.db_estado), 32'(ESPERA_SOLTAR));
    ciclos(1);
    chk("multi_ocioso", 32'(bus.db_estado), 32'(OCIOSO));

    // Press held while disabled, then enabled.
    bus.habilita = 1'b0;
    bus.botoes   = 4'b1000;
    ciclos(4);
    chk("gate_ocioso", 32'(bus.db_estado), 32'(OCIOSO));
    bus.habilita = 1'b1;
    prever(4'b1000, D + 1);
    ciclos(2);
    chk("gate_filtra", 32'(bus.db_estado), 32'(FILTRA));
    ciclos(8);
    chk("gate_jogada", 32'(bus.jogada), 32'h8);
    bus.botoes = '0;
    espera_estado("gate_solta", OCIOSO, 20);

    // Enable dropped mid-filter.
    bus.habilita = 1'b0;
    bus.botoes   = 4'b1000;
    ciclos(4);
    bus.habilita = 1'b1;
    ciclos(2);
    chk("abort_filtra", 32'(bus.db_estado), 32'(FILTRA));
    bus.habilita = 1'b0;
    ciclos(1);
    chk("abort_espera", 32'(bus.db_estado), 32'(ESPERA_SOLTAR));
    bus.botoes = '0;
    espera_estado("abort_solta", OCIOSO, 20);
    chk("abort_jogada", 32'(bus.jogada), 32'h8);

    // Synchronous clear during filtering.
    bus.habilita = 1'b1;
    bus.botoes   = 4'b0001;
    ciclos(4);
    chk("zera_filtra", 32'(bus.db_estado), 32'(FILTRA));
    bus.zera = 1'b1;
    ciclos(1);
    bus.zera = 1'b0;
    chk("zera_jogada", 32'(bus.jogada), 32'd0);
    chk("zera_estado", 32'(bus.db_estado), 32'(ESPERA_SOLTAR));
    ciclos(10);
    chk("zera_segura", 32'(bus.db_estado), 32'(ESPERA_SOLTAR));
    bus.botoes = '0;
    espera_estado("zera_solta", OCIOSO, 20);
    chk("zera_jogada_final", 32'(bus.jogada), 32'd0);

    // Asynchronous reset inside the pulse cycle.
    bus.botoes = 4'b0100;
    prever(4'b0100, D + 3);
    ciclos(D + 3);
    #1;
    chk("pulso_fez", 32'(bus.fez_jogada), 32'd1);
    chk("pulso_jogada_valida", 32'(bus.jogada), 32'h4);
    reset = 1'b0;
    #1;
    chk("rst_fez", 32'(bus.fez_jogada), 32'd0);
    chk("rst_jogada", 32'(bus.jogada), 32'd0);
    chk("rst_estado", 32'(bus.db_estado), 32'(OCIOSO));
    ciclos(3);
    chk("rst_fez_mantido", 32'(bus.fez_jogada), 32'd0);
    chk("rst_estado_mantido", 32'(bus.db_estado), 32'(OCIOSO));
    bus.botoes = '0;
    reset      = 1'b1;
    ciclos(12);
    chk("rst_pos_estado", 32'(bus.db_estado), 32'(OCIOSO));
    chk("fila_vazia", 32'(fila.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
